count_ctrl: RTL

Job controller and arbiter for the shared loadable up/down counter. Up to N requesters each submit a counting job (start value, direction, end value). The controller grants one job at a time, loads the counter, lets it run, and detects the end value. It then parks the counter and signals completion to the owning requester. It sits between the requester logic and the counter's `load`/`data_in`/`up_down` inputs inside the counter subsystem.

---
 rtl/count_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - job controller and arbiter for a shared loadable up/down counter
// Optional round-robin arbitration: define COUNT_CTRL_RR_EN (default is fixed priority, lowest index wins).
module count_ctrl #(
  parameter int N     = 4,
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_start,
  input  logic [N-1:0]         req_up,
  input  logic [N*WIDTH-1:0]   req_end,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         done,
  output logic                 busy,
  output logic                 cnt_load,
  output logic [WIDTH-1:0]     cnt_data,
  output logic                 cnt_up_down,
  input  logic [WIDTH-1:0]     cnt_count
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  job_start_q, job_end_q, park_q;
  logic              job_up_q;
  logic [IW-1:0]     owner_q;
  logic [IW-1:0]     win_idx, arb_idx;
  logic              win_any;
  logic              take;
  logic              match;

`ifdef COUNT_CTRL_RR_EN
  logic [IW-1:0]     ptr_q;

  // Search begins at ptr_q, which always points one past the last winner.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < N; k++) begin
      arb_idx = IW'((int'(ptr_q) + k) % N);
      if (!win_any && req[arb_idx]) begin
        win_any = 1'b1;
        win_idx = arb_idx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    arb_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      arb_idx = IW'(k);
      if (req[arb_idx]) begin
        win_any = 1'b1;
        win_idx = arb_idx;
      end
    end
  end
`endif

  assign take  = (state_q == S_IDLE) && win_any;
  assign match = (cnt_count == job_end_q);

  // Idle keeps reloading park_q so the counter stays frozen between jobs.
  always_comb begin
    state_d     = state_q;
    gnt         = '0;
    done        = '0;
    busy        = 1'b0;
    cnt_load    = 1'b1;
    cnt_data    = park_q;
    cnt_up_down = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_any && !reset) begin
          gnt     = N'(1) << win_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy        = 1'b1;
        cnt_data    = job_start_q;
        cnt_up_down = job_up_q;
        state_d     = S_RUN;
      end
      S_RUN: begin
        busy        = 1'b1;
        cnt_up_down = job_up_q;
        if (match) begin
          cnt_data = job_end_q;
          done     = N'(1) << owner_q;
          state_d  = S_IDLE;
        end else begin
          cnt_load = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      job_start_q <= '0;
      job_end_q   <= '0;
      job_up_q    <= 1'b0;
      owner_q     <= '0;
      park_q      <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q     <= win_idx;
        job_start_q <= req_start[win_idx*WIDTH +: WIDTH];
        job_end_q   <= req_end[win_idx*WIDTH +: WIDTH];
        job_up_q    <= req_up[win_idx];
      end
      if (state_q == S_RUN && match) begin
        park_q <= job_end_q;
      end
    end
  end

endmodule
